// File: rtl/prefix_sub_seq.sv
// Multi-cycle Kogge-Stone subtractor: one prefix level per clock, with Y86 ZF/SF/OF flags.
// Optional add/sub select port enabled by defining PREFIX_SUB_ADD_MODE_EN.
module prefix_sub_seq #(
    parameter int unsigned WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef PREFIX_SUB_ADD_MODE_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             zf,
    output logic             sf,
    output logic             of,
    output logic             borrow
);

    localparam int unsigned LEVELS = $clog2(WIDTH);
    localparam int unsigned KW     = $clog2(LEVELS);
    localparam logic [KW-1:0] LastK = KW'(LEVELS - 1);

    typedef enum logic [1:0] {StIdle, StPrefix, StFinal} state_e;

    state_e           state_q, state_d;
    logic [KW-1:0]    k_q, k_d;
    logic [WIDTH-1:0] p0_q, p0_d, p_q, p_d, g_q, g_d;
    logic             cin_q, cin_d, a_msb_q, a_msb_d, b_msb_q, b_msb_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             zf_q, zf_d, sf_q, sf_d, of_q, of_d, borrow_q, borrow_d, done_q, done_d;

    logic             sub_in;
    logic [WIDTH-1:0] b_eff, p_init, g_init, span, low_mask, p_next, g_next, sum;

`ifdef PREFIX_SUB_ADD_MODE_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b1;
`endif

    always_comb begin
        b_eff     = sub_in ? ~b : b;
        p_init    = a ^ b_eff;
        g_init    = a & b_eff;
        // Carry-in folds into bit 0 so the tree only ever propagates generate terms.
        g_init[0] = g_init[0] | (p_init[0] & sub_in);

        span     = WIDTH'(1) << k_q;
        low_mask = span - WIDTH'(1);
        p_next   = p_q & ((p_q << span) | low_mask);
        g_next   = g_q | (p_q & (g_q << span));

        sum = p0_q ^ {g_q[WIDTH-2:0], cin_q};
    end

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        p0_d     = p0_q;
        p_d      = p_q;
        g_d      = g_q;
        cin_d    = cin_q;
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        diff_d   = diff_q;
        zf_d     = zf_q;
        sf_d     = sf_q;
        of_d     = of_q;
        borrow_d = borrow_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    p0_d    = p_init;
                    p_d     = p_init;
                    g_d     = g_init;
                    cin_d   = sub_in;
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
                    k_d     = '0;
                    state_d = StPrefix;
                end
            end
            StPrefix: begin
                p_d = p_next;
                g_d = g_next;
                if (k_q == LastK) begin
                    k_d     = '0;
                    state_d = StFinal;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            StFinal: begin
                diff_d   = sum;
                zf_d     = (sum == '0);
                sf_d     = sum[WIDTH-1];
                // Subtract overflows on differing signs, add on matching signs.
                of_d     = cin_q ? ((a_msb_q != b_msb_q) && (sum[WIDTH-1] != a_msb_q))
                                 : ((a_msb_q == b_msb_q) && (sum[WIDTH-1] != a_msb_q));
                borrow_d = cin_q ? ~g_q[WIDTH-1] : g_q[WIDTH-1];
                done_d   = 1'b1;
                state_d  = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= StIdle;
            k_q      <= '0;
            p0_q     <= '0;
            p_q      <= '0;
            g_q      <= '0;
            cin_q    <= 1'b0;
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            diff_q   <= '0;
            zf_q     <= 1'b0;
            sf_q     <= 1'b0;
            of_q     <= 1'b0;
            borrow_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            k_q      <= k_d;
            p0_q     <= p0_d;
            p_q      <= p_d;
            g_q      <= g_d;
            cin_q    <= cin_d;
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            diff_q   <= diff_d;
            zf_q     <= zf_d;
            sf_q     <= sf_d;
            of_q     <= of_d;
            borrow_q <= borrow_d;
            done_q   <= done_d;
        end
    end

    assign busy   = (state_q != StIdle);
    assign done   = done_q;
    assign diff   = diff_q;
    assign zf     = zf_q;
    assign sf     = sf_q;
    assign of     = of_q;
    assign borrow = borrow_q;

endmodule

// File: tb/tb_prefix_sub_seq.sv
// Directed bench for prefix_sub_seq at WIDTH=64: latency, flags, back-to-back, ignored start,
// mid-operation reset, and (with PREFIX_SUB_ADD_MODE_EN) add mode.
module tb_prefix_sub_seq;

    logic        clk = 1'b0;
    logic        rst, start;
    logic [63:0] a, b;
`ifdef PREFIX_SUB_ADD_MODE_EN
    logic        sub;
`endif
    logic        busy, done, zf, sf, of, borrow;
    logic [63:0] diff;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    prefix_sub_seq #(.WIDTH(64)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .a      (a),
        .b      (b),
`ifdef PREFIX_SUB_ADD_MODE_EN
        .sub    (sub),
`endif
        .busy   (busy),
        .done   (done),
        .diff   (diff),
        .zf     (zf),
        .sf     (sf),
        .of     (of),
        .borrow (borrow)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pulses start for one cycle, then scrambles the operands to show they were captured.
    task automatic launch(input logic [63:0] av, input logic [63:0] bv);
        a     = av;
        b     = bv;
        start = 1'b1;
        tick();
        start = 1'b0;
        a     = ~av;
        b     = {$urandom, $urandom};
    endtask

    task automatic run_op(input string name, input logic [63:0] av, input logic [63:0] bv,
                          input logic [63:0] ed, input logic ezf, input logic esf,
                          input logic eof, input logic ebr);
        launch(av, bv);
        for (int c = 0; c < 7; c++) begin
            chk({name, ".busy"}, 64'(busy), 64'd1);
            chk({name, ".done_early"}, 64'(done), 64'd0);
            if (c < 6) tick();
        end
        tick();
        chk({name, ".done"}, 64'(done), 64'd1);
        chk({name, ".busy_end"}, 64'(busy), 64'd0);
        chk({name, ".diff"}, diff, ed);
        chk({name, ".zf"}, 64'(zf), 64'(ezf));
        chk({name, ".sf"}, 64'(sf), 64'(esf));
        chk({name, ".of"}, 64'(of), 64'(eof));
        chk({name, ".borrow"}, 64'(borrow), 64'(ebr));
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
`ifdef PREFIX_SUB_ADD_MODE_EN
        sub   = 1'b1;
`endif
        tick();
        tick();
        rst = 1'b0;
        chk("reset.busy", 64'(busy), 64'd0);
        chk("reset.done", 64'(done), 64'd0);
        chk("reset.diff", diff, 64'd0);
        chk("reset.flags", {60'd0, zf, sf, of, borrow}, 64'd0);

        run_op("sub5_3", 64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b0, 1'b0);
        run_op("sub0_1", 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("min_1", 64'h8000_0000_0000_0000, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF,
               1'b0, 1'b0, 1'b1, 1'b0);
        run_op("max_m1", 64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b1, 1'b1);
        run_op("sub3_5", 64'd3, 64'd5, 64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b1, 1'b0, 1'b1);
        run_op("equal", 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0,
               1'b1, 1'b0, 1'b0, 1'b0);
        // Launched in the done cycle of the previous operation.
        run_op("b2b", 64'd10, 64'd4, 64'd6, 1'b0, 1'b0, 1'b0, 1'b0);

        // Start re-pulsed three cycles after acceptance must be ignored.
        launch(64'd20, 64'd7);
        tick();
        tick();
        a     = 64'd100;
        b     = 64'd1;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        chk("ign.no_done_yet", 64'(done), 64'd0);
        tick();
        chk("ign.done", 64'(done), 64'd1);
        chk("ign.diff", diff, 64'd13);
        for (int c = 0; c < 10; c++) begin
            tick();
            chk("ign.single_done", 64'(done), 64'd0);
            chk("ign.idle", 64'(busy), 64'd0);
            chk("ign.hold_diff", diff, 64'd13);
        end

        // Reset four cycles into an operation aborts it with no done.
        launch(64'd50, 64'd8);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst.busy", 64'(busy), 64'd0);
        chk("rst.done", 64'(done), 64'd0);
        chk("rst.diff", diff, 64'd0);
        chk("rst.flags", {60'd0, zf, sf, of, borrow}, 64'd0);
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("rst.no_done", 64'(done), 64'd0);
        end
        run_op("after_rst", 64'd50, 64'd8, 64'd42, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef PREFIX_SUB_ADD_MODE_EN
        sub = 1'b0;
        run_op("add_wrap", 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1);
        run_op("add_ovf", 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'h8000_0000_0000_0000,
               1'b0, 1'b1, 1'b1, 1'b0);
        sub = 1'b1;
        run_op("sub_again", 64'd9, 64'd9, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
